sram_read_arbiter: RTL and testbench

Shares the two read ports and one write port of a 2R1W block SRAM among NUM_REQUESTERS read clients and one write client. It grants up to two reads per cycle using a round-robin order and routes each SRAM result back to the client that issued the read. After reset it zero-fills the whole SRAM before accepting any traffic. It sits between pipeline clients (tag/data lookups) and the SRAM instance, which is configured for NEW_DATA read-during-write behaviour.

---
 rtl/sram_read_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_sram_read_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_read_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sram_read_arbiter                                               |
// | Brief    : Shares a 2R1W SRAM among NUM_REQUESTERS round-robin read        |
// |            clients and one write client; zero-fills the SRAM after reset.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module sram_read_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int SIZE           = 1024,
  parameter int NUM_REQUESTERS = 4,
  parameter int ADDR_WIDTH     = $clog2(SIZE)
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  // read clients
  input  logic [NUM_REQUESTERS-1:0]            req_valid,
  input  logic [NUM_REQUESTERS*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQUESTERS-1:0]            req_ready,
  output logic [NUM_REQUESTERS-1:0]            resp_valid,
  output logic [NUM_REQUESTERS*DATA_WIDTH-1:0] resp_data,
  // write client
  input  logic                                 wr_valid,
  input  logic [ADDR_WIDTH-1:0]                wr_addr,
  input  logic [DATA_WIDTH-1:0]                wr_data,
  output logic                                 wr_ready,
  output logic                                 init_done,
  // SRAM read ports
  output logic                                 sram_read1_en,
  output logic [ADDR_WIDTH-1:0]                sram_read1_addr,
  output logic                                 sram_read2_en,
  output logic [ADDR_WIDTH-1:0]                sram_read2_addr,
  input  logic [DATA_WIDTH-1:0]                sram_read1_data,
  input  logic [DATA_WIDTH-1:0]                sram_read2_data,
  // SRAM write port
  output logic                                 sram_write_en,
  output logic [ADDR_WIDTH-1:0]                sram_write_addr,
  output logic [DATA_WIDTH-1:0]                sram_write_data
);

  localparam int IDX_W = $clog2(NUM_REQUESTERS);
  // One extra bit so a power-of-two SIZE never wraps the sweep back to 0.
  localparam int CNT_W = ADDR_WIDTH + 1;

  localparam logic [CNT_W-1:0] c_LAST_ADDR = CNT_W'(SIZE - 1);
  localparam logic [IDX_W:0]   c_NUM_REQ   = (IDX_W + 1)'(NUM_REQUESTERS);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                    r_state;
  state_t                    w_state_next;
  logic [CNT_W-1:0]          r_sweep;
  logic [IDX_W-1:0]          r_rr_ptr;
  logic [IDX_W-1:0]          w_rr_next;
  logic [NUM_REQUESTERS-1:0] r_resp_valid;
  logic [NUM_REQUESTERS-1:0] r_port_sel;

  // Reset gates every output so nothing leaks to the SRAM while reset_n is low.
  logic w_init;
  logic w_run;

  logic                      w_g1_found;
  logic                      w_g2_found;
  logic [IDX_W-1:0]          w_g1_idx;
  logic [IDX_W-1:0]          w_g2_idx;
  logic [NUM_REQUESTERS-1:0] w_grant1;
  logic [NUM_REQUESTERS-1:0] w_grant2;
  logic [IDX_W:0]            w_sum;
  logic [IDX_W-1:0]          w_cand;
  logic [IDX_W-1:0]          w_last;
  logic [IDX_W:0]            w_last_inc;

  logic [ADDR_WIDTH-1:0]     w_req_addr [NUM_REQUESTERS];

  // Unpack the flat per-client address bus.
  generate
    for (genvar gi = 0; gi < NUM_REQUESTERS; gi++) begin : g_unpack
      assign w_req_addr[gi] = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    end
  endgenerate

  // State register: reset always returns to the zero-fill sweep.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and SRAM write port: sweep writes zeros, then pass the write client through.
  always_comb begin
    w_state_next    = r_state;
    w_init          = 1'b0;
    w_run           = 1'b0;
    sram_write_en   = 1'b0;
    sram_write_addr = '0;
    sram_write_data = '0;
    case (r_state)
      ST_INIT: begin
        w_init = reset_n;
        if (r_sweep == c_LAST_ADDR) begin
          w_state_next = ST_RUN;
        end
        if (reset_n) begin
          sram_write_en   = 1'b1;
          sram_write_addr = r_sweep[ADDR_WIDTH-1:0];
        end
      end
      ST_RUN: begin
        w_run = reset_n;
        if (reset_n) begin
          sram_write_en   = wr_valid;
          sram_write_addr = wr_addr;
          sram_write_data = wr_data;
        end
      end
      default: begin
        w_state_next = ST_INIT;
      end
    endcase
  end

  // Sweep address counter; saturates at SIZE once the sweep is done.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sweep <= '0;
    end else if (r_state == ST_INIT) begin
      r_sweep <= r_sweep + CNT_W'(1);
    end
  end

  // Round-robin scan from rr_ptr: first valid client takes port 1, second takes port 2.
  always_comb begin
    w_g1_found = 1'b0;
    w_g2_found = 1'b0;
    w_g1_idx   = '0;
    w_g2_idx   = '0;
    w_grant1   = '0;
    w_grant2   = '0;
    w_sum      = '0;
    w_cand     = '0;
    for (int k = 0; k < NUM_REQUESTERS; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (IDX_W + 1)'(k);
      if (w_sum >= c_NUM_REQ) begin
        w_sum = w_sum - c_NUM_REQ;
      end
      w_cand = w_sum[IDX_W-1:0];
      if (w_run && req_valid[w_cand]) begin
        if (!w_g1_found) begin
          w_g1_found       = 1'b1;
          w_g1_idx         = w_cand;
          w_grant1[w_cand] = 1'b1;
        end else if (!w_g2_found) begin
          w_g2_found       = 1'b1;
          w_g2_idx         = w_cand;
          w_grant2[w_cand] = 1'b1;
        end
      end
    end
  end

  // Pointer advances past the last client granted this cycle.
  always_comb begin
    w_rr_next  = r_rr_ptr;
    w_last     = w_g2_found ? w_g2_idx : w_g1_idx;
    w_last_inc = {1'b0, w_last} + (IDX_W + 1)'(1);
    if (w_last_inc >= c_NUM_REQ) begin
      w_last_inc = w_last_inc - c_NUM_REQ;
    end
    if (w_g1_found) begin
      w_rr_next = w_last_inc[IDX_W-1:0];
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rr_ptr <= '0;
    end else begin
      r_rr_ptr <= w_rr_next;
    end
  end

  // Remember which clients were granted and on which port, for next-cycle routing.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_resp_valid <= '0;
      r_port_sel   <= '0;
    end else begin
      r_resp_valid <= w_grant1 | w_grant2;
      r_port_sel   <= w_grant2;
    end
  end

  // Read port drive; idle ports park at address 0.
  always_comb begin
    req_ready       = w_grant1 | w_grant2;
    sram_read1_en   = w_g1_found;
    sram_read2_en   = w_g2_found;
    sram_read1_addr = w_g1_found ? w_req_addr[w_g1_idx] : '0;
    sram_read2_addr = w_g2_found ? w_req_addr[w_g2_idx] : '0;
  end

  assign resp_valid = r_resp_valid & {NUM_REQUESTERS{reset_n}};
  assign wr_ready   = w_run;
  assign init_done  = w_run;

  // Each client sees the data of the port it was granted last cycle.
  generate
    for (genvar gi = 0; gi < NUM_REQUESTERS; gi++) begin : g_resp
      assign resp_data[gi*DATA_WIDTH +: DATA_WIDTH] =
        r_port_sel[gi] ? sram_read2_data : sram_read1_data;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sram_read_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_sram_read_arbiter                                            |
// | Brief    : Self-checking bench for sram_read_arbiter with a 2R1W           |
// |            NEW_DATA SRAM model and a reference model of the arbiter.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_sram_read_arbiter;

  localparam int DW = 32;
  localparam int SZ = 16;
  localparam int N  = 4;
  localparam int AW = $clog2(SZ);

  logic            clk;
  logic            reset_n;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    resp_valid;
  logic [N*DW-1:0] resp_data;
  logic            wr_valid;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic            wr_ready;
  logic            init_done;
  logic            sram_read1_en;
  logic [AW-1:0]   sram_read1_addr;
  logic            sram_read2_en;
  logic [AW-1:0]   sram_read2_addr;
  logic [DW-1:0]   sram_read1_data;
  logic [DW-1:0]   sram_read2_data;
  logic            sram_write_en;
  logic [AW-1:0]   sram_write_addr;
  logic [DW-1:0]   sram_write_data;

  sram_read_arbiter #(
    .DATA_WIDTH(DW), .SIZE(SZ), .NUM_REQUESTERS(N), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .init_done(init_done),
    .sram_read1_en(sram_read1_en), .sram_read1_addr(sram_read1_addr),
    .sram_read2_en(sram_read2_en), .sram_read2_addr(sram_read2_addr),
    .sram_read1_data(sram_read1_data), .sram_read2_data(sram_read2_data),
    .sram_write_en(sram_write_en), .sram_write_addr(sram_write_addr),
    .sram_write_data(sram_write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 2R1W SRAM, one-cycle read latency, NEW_DATA on read-during-write.
  logic [DW-1:0] sram_mem [SZ];
  always @(posedge clk) begin
    if (sram_read1_en)
      sram_read1_data <= (sram_write_en && sram_write_addr == sram_read1_addr) ?
                         sram_write_data : sram_mem[sram_read1_addr];
    if (sram_read2_en)
      sram_read2_data <= (sram_write_en && sram_write_addr == sram_read2_addr) ?
                         sram_write_data : sram_mem[sram_read2_addr];
    if (sram_write_en) sram_mem[sram_write_addr] <= sram_write_data;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state.
  int            m_mode = 0;  // 0 = sweeping, 1 = serving
  int            m_cnt  = 0;
  int            m_rr   = 0;
  logic [DW-1:0] m_mem      [SZ];
  logic [N-1:0]  m_exp_valid = '0;
  logic [DW-1:0] m_exp_data [N];

  always @(negedge clk) begin : p_compare
    int first;
    int second;
    int idx;
    logic [N-1:0] g;
    if (!reset_n) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_init_done", init_done, 0);
      chk("rst_enables", {sram_read1_en, sram_read2_en, sram_write_en}, 0);
      chk("rst_addrs", {sram_read1_addr, sram_read2_addr, sram_write_addr}, 0);
      m_mode = 0; m_cnt = 0; m_rr = 0; m_exp_valid = '0;
    end else if (m_mode == 0) begin
      chk("init_wr_en", sram_write_en, 1);
      chk("init_wr_addr", sram_write_addr, m_cnt);
      chk("init_wr_data", sram_write_data, 0);
      chk("init_req_ready", req_ready, 0);
      chk("init_rd_en", {sram_read1_en, sram_read2_en}, 0);
      chk("init_done_low", init_done, 0);
      chk("init_wr_ready", wr_ready, 0);
      chk("init_resp_valid", resp_valid, 0);
      m_mem[m_cnt] = '0;
      m_cnt++;
      if (m_cnt == SZ) m_mode = 1;
    end else begin
      chk("run_init_done", init_done, 1);
      chk("run_wr_ready", wr_ready, 1);
      chk("run_wr_en", sram_write_en, wr_valid);
      if (wr_valid) begin
        chk("run_wr_addr", sram_write_addr, wr_addr);
        chk("run_wr_data", sram_write_data, wr_data);
      end
      chk("resp_valid", resp_valid, m_exp_valid);
      for (int i = 0; i < N; i++)
        if (m_exp_valid[i]) chk($sformatf("resp_data%0d", i), resp_data[i*DW +: DW], m_exp_data[i]);
      first = -1; second = -1;
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        if (req_valid[idx]) begin
          if (first < 0) first = idx;
          else if (second < 0) second = idx;
        end
      end
      g = '0;
      if (first >= 0) g[first] = 1'b1;
      if (second >= 0) g[second] = 1'b1;
      chk("req_ready", req_ready, g);
      chk("rd1_en", sram_read1_en, first >= 0);
      chk("rd2_en", sram_read2_en, second >= 0);
      if (first >= 0) chk("rd1_addr", sram_read1_addr, req_addr[first*AW +: AW]);
      if (second >= 0) chk("rd2_addr", sram_read2_addr, req_addr[second*AW +: AW]);
      if (wr_valid) m_mem[wr_addr] = wr_data;
      m_exp_valid = g;
      for (int i = 0; i < N; i++)
        if (g[i]) m_exp_data[i] = m_mem[req_addr[i*AW +: AW]];
      if (second >= 0) m_rr = (second + 1) % N;
      else if (first >= 0) m_rr = (first + 1) % N;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_inputs();
    req_valid = N'($urandom);
    req_addr  = (N*AW)'($urandom);
    wr_valid  = 1'($urandom);
    wr_addr   = AW'($urandom_range(0, SZ-1));
    wr_data   = $urandom;
  endtask

  initial begin : p_stim
    reset_n = 1'b0; req_valid = '0; req_addr = '0;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    for (int i = 0; i < SZ; i++) sram_mem[i] = $urandom;
    repeat (3) next_cycle();
    @(negedge clk);
    chk("lit_rst_init_done", init_done, 0);

    // Partial sweep, then reset at address 9.
    next_cycle();
    reset_n = 1'b1; req_valid = '1; req_addr = 16'h3210;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("lit_sweep1_addr", sram_write_addr, c);
      next_cycle();
    end
    reset_n = 1'b0;
    @(negedge clk);
    chk("lit_midsweep_rst_wen", sram_write_en, 0);
    next_cycle();
    @(negedge clk);
    chk("lit_midsweep_init_done", init_done, 0);
    next_cycle();
    reset_n = 1'b1;

    // Full sweep.
    for (int c = 0; c < SZ; c++) begin
      @(negedge clk);
      chk("lit_sweep_addr", sram_write_addr, c);
      chk("lit_sweep_ready", req_ready, 0);
      chk("lit_sweep_done", init_done, 0);
      next_cycle();
    end

    // Cycle SZ: init complete; store 0x12345678 at address 7.
    req_valid = '0; wr_valid = 1'b1; wr_addr = 4'd7; wr_data = 32'h12345678;
    @(negedge clk);
    chk("lit_init_done", init_done, 1);
    chk("lit_wr_ready", wr_ready, 1);
    next_cycle();

    // Round-robin with all clients valid.
    wr_addr = 4'd3; wr_data = 32'hA5A5_0003;
    req_valid = 4'b1111; req_addr = {4'd2, 4'd1, 4'd3, 4'd7};
    @(negedge clk);
    chk("lit_rr0", req_ready, 4'b0011);
    next_cycle();
    wr_valid = 1'b0;
    @(negedge clk);
    chk("lit_rr1", req_ready, 4'b1100);
    chk("lit_rr1_resp_valid", resp_valid, 4'b0011);
    chk("lit_rr1_data0", resp_data[0 +: DW], 32'h12345678);
    next_cycle();
    @(negedge clk);
    chk("lit_rr2", req_ready, 4'b0011);
    chk("lit_rr2_resp_valid", resp_valid, 4'b1100);
    next_cycle();

    // Dual read of the same address.
    req_valid = 4'b0011; req_addr = {4'd0, 4'd0, 4'd7, 4'd7};
    @(negedge clk);
    chk("lit_dual_ready", req_ready, 4'b0011);
    chk("lit_dual_addrs", {sram_read1_addr, sram_read2_addr}, {4'd7, 4'd7});
    next_cycle();

    // Read-after-write on address 5 by client 2.
    req_valid = 4'b0100; req_addr = {4'd0, 4'd5, 4'd0, 4'd0};
    wr_valid = 1'b1; wr_addr = 4'd5; wr_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("lit_dual_resp_valid", resp_valid, 4'b0011);
    chk("lit_dual_data0", resp_data[0 +: DW], 32'h12345678);
    chk("lit_dual_data1", resp_data[DW +: DW], 32'h12345678);
    chk("lit_raw_ready", req_ready, 4'b0100);
    next_cycle();

    // Single requester at rr_ptr=3.
    wr_valid = 1'b0;
    req_valid = 4'b1000; req_addr = {4'd9, 4'd0, 4'd0, 4'd0};
    @(negedge clk);
    chk("lit_raw_valid", resp_valid[2], 1);
    chk("lit_raw_data", resp_data[2*DW +: DW], 32'hDEADBEEF);
    chk("lit_single_ready", req_ready, 4'b1000);
    chk("lit_single_ens", {sram_read1_en, sram_read2_en}, 2'b10);
    next_cycle();
    req_valid = 4'b1111;
    @(negedge clk);
    chk("lit_wrap_ready", req_ready, 4'b0011);
    next_cycle();

    // Random traffic.
    for (int c = 0; c < 300; c++) begin
      randomize_inputs();
      next_cycle();
    end

    // Reset with a read in flight.
    req_valid = 4'b1111; wr_valid = 1'b0;
    next_cycle();
    reset_n = 1'b0; req_valid = '0;
    @(negedge clk);
    chk("lit_inflight_rst_valid", resp_valid, 0);
    next_cycle();
    @(negedge clk);
    chk("lit_inflight_rst_valid2", resp_valid, 0);
    next_cycle();
    reset_n = 1'b1;

    for (int c = 0; c < 300; c++) begin
      randomize_inputs();
      next_cycle();
    end
    req_valid = '0; wr_valid = 1'b0;
    repeat (2) next_cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
